cf_commit_queue: RTL and testbench
==================================

Name: cf_commit_queue

Overview:
- In-order queue that tracks every conditional branch and jump-register from dispatch through execution to ROB retirement.
- Acts as the producer side of the branch-commit and jump-reg-commit interfaces that the hazard controller consumes.
- Emits exactly one registered commit pulse per control-flow instruction, in program order, when the instruction is resolved and is the ROB head.
- Sits between decode/dispatch (allocation), the ALU reservation-station writeback (resolution) and the ROB head (retirement).

Parameters:
DEPTH, 8, number of control-flow entries (power of two, at least 2).
DEPTH_BITS, 3, log2(DEPTH).
ROB_IDX_W, 4, width of a ROB entry index.

Ports:
clk  in  1  clock, all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
alloc_valid  in  1  dispatch of a branch or jump-register this cycle.
alloc_is_jr  in  1  1 = jump-register, 0 = conditional branch.
alloc_rob_idx  in  ROB_IDX_W  ROB slot of the allocating instruction.
alloc_ready  out  1  queue can accept an allocation (registered count < DEPTH).
alloc_tag  out  DEPTH_BITS  tag the allocation receives (current write pointer, low bits).
res_valid  in  1  ALU resolution of a tagged entry.
res_tag  in  DEPTH_BITS  tag being resolved.
res_taken  in  1  branch outcome (1 = TAKEN); ignored for jump-register.
res_target  in  32  computed jump-register target; ignored for branches.
rob_head_valid  in  1  ROB head is valid.
rob_head_idx  in  ROB_IDX_W  ROB head slot.
flush  in  1  pipeline flush from the hazard controller; discards all entries.
valid_branch  out  1  one-cycle branch-commit pulse.
branch_outcome  out  1  committed branch outcome.
valid_jump_reg  out  1  one-cycle jump-register-commit pulse.
jump_target  out  32  committed jump-register target.
count  out  DEPTH_BITS+1  current occupancy.
err_sticky  out  1  protocol-violation flag; held until reset.

Behaviour:
- Entry fields: valid, resolved, is_jr, rob_idx, taken, target.
- Pointers: wr_ptr and rd_ptr are DEPTH_BITS+1 wide, including a wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = low bits equal and wrap bits differ.
  - count = wr_ptr − rd_ptr.
- Reset (rst=1 at an edge): clear all entries, both pointers, count, valid_branch, valid_jump_reg, branch_outcome, jump_target, err_sticky. Reset mid-operation discards everything, and no pulse is emitted in the following cycle.
- Allocate: when alloc_valid & alloc_ready & !flush:
  - write the entry at wr_ptr with resolved=0;
  - increment wr_ptr.
  - alloc_tag is valid in the same cycle.
  - alloc_valid while !alloc_ready is dropped and sets err_sticky.
- Resolve: when res_valid & !flush and entry[res_tag] is valid and unresolved:
  - set resolved=1 and store taken/target.
  - A resolution to an invalid or already-resolved entry is ignored and sets err_sticky.
  - A resolution written in cycle N is visible to the commit check from cycle N+1 (no bypass).
- Commit fire (combinational) = !empty & head.resolved & rob_head_valid & (rob_head_idx == head.rob_idx) & !flush.
  - On fire, pop the head (rd_ptr+1, clear the valid bit).
  - Next edge, the outputs register:
    - for a branch: valid_branch=1, branch_outcome=head.taken;
    - for a jump-register: valid_jump_reg=1, jump_target=head.target.
  - Latency is 1 cycle from fire to pulse. Pulses last exactly one cycle; otherwise both valid outputs are 0. branch_outcome and jump_target hold their last value.
  - At most one commit per cycle.
- Allocate and commit in the same cycle: both take effect, and count is unchanged.
  - alloc_ready is derived from the registered count, so a full queue rejects allocation even while popping.
- Flush: on the next edge, invalidate all entries and set rd_ptr = wr_ptr.
  - Flush has priority over allocate, resolve and commit in the same cycle; all are suppressed.
  - Registered output pulses already in flight at the flush edge still appear.
- Wrap-around: pointers wrap modulo 2·DEPTH. Tags reuse low bits, which is safe because at most DEPTH entries are live.

Test Plan:
- Reset then idle → count=0, alloc_ready=1, no pulses, err_sticky=0.
- Allocate branch (rob_idx 3) as tag 0; resolve taken=1 at cycle 2; rob_head_idx=3 from cycle 3 → valid_branch=1, branch_outcome=1 at cycle 4 only; count back to 0.
- Allocate jr (tag 0, rob 5) then branch (tag 1, rob 6); resolve tag 1 first, then tag 0 with target 0x0040_0100; ROB head advances 5→6 → valid_jump_reg with jump_target=0x0040_0100 precedes valid_branch; no out-of-order pulse.
- Fill 8 entries → alloc_ready=0, count=8; a 9th alloc_valid sets err_sticky=1. Commit 3, then allocate 3 more → pointers wrap and tags 0,1,2 are reissued correctly.
- 4 live entries, flush asserted together with alloc_valid and a commit-eligible head → no pulse next cycle, count=0, dropped allocation not stored.
- rst asserted while 5 entries live with head commit-eligible → all outputs 0 next cycle, count=0, err_sticky=0.

Source files
------------

// File: rtl/cf_commit_queue.sv
// rtl/cf_commit_queue.sv - in-order branch/jump-register commit queue feeding the hazard controller
module cf_commit_queue #(
  parameter int DEPTH      = 8,
  parameter int DEPTH_BITS = 3,
  parameter int ROB_IDX_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid,
  input  logic                  alloc_is_jr,
  input  logic [ROB_IDX_W-1:0]  alloc_rob_idx,
  output logic                  alloc_ready,
  output logic [DEPTH_BITS-1:0] alloc_tag,
  input  logic                  res_valid,
  input  logic [DEPTH_BITS-1:0] res_tag,
  input  logic                  res_taken,
  input  logic [31:0]           res_target,
  input  logic                  rob_head_valid,
  input  logic [ROB_IDX_W-1:0]  rob_head_idx,
  input  logic                  flush,
  output logic                  valid_branch,
  output logic                  branch_outcome,
  output logic                  valid_jump_reg,
  output logic [31:0]           jump_target,
  output logic [DEPTH_BITS:0]   count,
  output logic                  err_sticky
);

  localparam logic [DEPTH_BITS:0] PTR_ONE = {{DEPTH_BITS{1'b0}}, 1'b1};

  // per-entry state, bit i belongs to tag i
  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [DEPTH-1:0]     resolved_q, resolved_d;
  logic [DEPTH-1:0]     is_jr_q, is_jr_d;
  logic [DEPTH-1:0]     taken_q, taken_d;
  logic [ROB_IDX_W-1:0] rob_idx_q [DEPTH];
  logic [ROB_IDX_W-1:0] rob_idx_d [DEPTH];
  logic [31:0]          target_q [DEPTH];
  logic [31:0]          target_d [DEPTH];

  // pointers carry a wrap bit above the tag bits
  logic [DEPTH_BITS:0]  wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS:0]  rd_ptr_q, rd_ptr_d;

  logic                 valid_branch_q, valid_branch_d;
  logic                 branch_outcome_q, branch_outcome_d;
  logic                 valid_jump_reg_q, valid_jump_reg_d;
  logic [31:0]          jump_target_q, jump_target_d;
  logic                 err_sticky_q, err_sticky_d;

  logic [DEPTH_BITS-1:0] wr_idx;
  logic [DEPTH_BITS-1:0] rd_idx;
  logic                  empty;
  logic                  full;
  logic                  alloc_fire;
  logic                  commit_fire;

  assign wr_idx = wr_ptr_q[DEPTH_BITS-1:0];
  assign rd_idx = rd_ptr_q[DEPTH_BITS-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_idx == rd_idx) && (wr_ptr_q[DEPTH_BITS] != rd_ptr_q[DEPTH_BITS]);

  // readiness comes from registered pointers only, so a same-cycle pop never frees a full queue
  assign alloc_ready = !full;
  assign alloc_tag   = wr_idx;
  assign count       = wr_ptr_q - rd_ptr_q;

  assign alloc_fire  = alloc_valid && alloc_ready && !flush;
  assign commit_fire = !empty && resolved_q[rd_idx] && rob_head_valid &&
                       (rob_head_idx == rob_idx_q[rd_idx]) && !flush;

  // next-state: flush wins outright, otherwise commit, allocate and resolve all apply
  always_comb begin
    valid_d          = valid_q;
    resolved_d       = resolved_q;
    is_jr_d          = is_jr_q;
    taken_d          = taken_q;
    rob_idx_d        = rob_idx_q;
    target_d         = target_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    valid_branch_d   = 1'b0;
    valid_jump_reg_d = 1'b0;
    branch_outcome_d = branch_outcome_q;
    jump_target_d    = jump_target_q;
    err_sticky_d     = err_sticky_q;

    if (flush) begin
      valid_d    = '0;
      resolved_d = '0;
      rd_ptr_d   = wr_ptr_q;
    end else begin
      if (commit_fire) begin
        valid_d[rd_idx] = 1'b0;
        rd_ptr_d        = rd_ptr_q + PTR_ONE;
        if (is_jr_q[rd_idx]) begin
          valid_jump_reg_d = 1'b1;
          jump_target_d    = target_q[rd_idx];
        end else begin
          valid_branch_d   = 1'b1;
          branch_outcome_d = taken_q[rd_idx];
        end
      end

      // the slot at wr_idx is never live when allocation is allowed, so it cannot clash with resolve
      if (alloc_fire) begin
        valid_d[wr_idx]    = 1'b1;
        resolved_d[wr_idx] = 1'b0;
        is_jr_d[wr_idx]    = alloc_is_jr;
        taken_d[wr_idx]    = 1'b0;
        rob_idx_d[wr_idx]  = alloc_rob_idx;
        target_d[wr_idx]   = '0;
        wr_ptr_d           = wr_ptr_q + PTR_ONE;
      end else if (alloc_valid && !alloc_ready) begin
        err_sticky_d = 1'b1;
      end

      if (res_valid) begin
        if (valid_q[res_tag] && !resolved_q[res_tag]) begin
          resolved_d[res_tag] = 1'b1;
          taken_d[res_tag]    = res_taken;
          target_d[res_tag]   = res_target;
        end else begin
          err_sticky_d = 1'b1;
        end
      end
    end
  end

  // state registers with synchronous reset that also kills any pending pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q          <= '0;
      resolved_q       <= '0;
      is_jr_q          <= '0;
      taken_q          <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rob_idx_q[i] <= '0;
        target_q[i]  <= '0;
      end
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      valid_branch_q   <= 1'b0;
      branch_outcome_q <= 1'b0;
      valid_jump_reg_q <= 1'b0;
      jump_target_q    <= '0;
      err_sticky_q     <= 1'b0;
    end else begin
      valid_q          <= valid_d;
      resolved_q       <= resolved_d;
      is_jr_q          <= is_jr_d;
      taken_q          <= taken_d;
      rob_idx_q        <= rob_idx_d;
      target_q         <= target_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      valid_branch_q   <= valid_branch_d;
      branch_outcome_q <= branch_outcome_d;
      valid_jump_reg_q <= valid_jump_reg_d;
      jump_target_q    <= jump_target_d;
      err_sticky_q     <= err_sticky_d;
    end
  end

  assign valid_branch   = valid_branch_q;
  assign branch_outcome = branch_outcome_q;
  assign valid_jump_reg = valid_jump_reg_q;
  assign jump_target    = jump_target_q;
  assign err_sticky     = err_sticky_q;

endmodule

// File: tb/tb_cf_commit_queue.sv
// tb/tb_cf_commit_queue.sv - scoreboard bench for cf_commit_queue
module tb_cf_commit_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic        alloc_is_jr;
  logic [3:0]  alloc_rob_idx;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        res_valid;
  logic [2:0]  res_tag;
  logic        res_taken;
  logic [31:0] res_target;
  logic        rob_head_valid;
  logic [3:0]  rob_head_idx;
  logic        flush;
  logic        valid_branch;
  logic        branch_outcome;
  logic        valid_jump_reg;
  logic [31:0] jump_target;
  logic [3:0]  count;
  logic        err_sticky;

  typedef struct packed {
    logic        is_jr;
    logic [31:0] val;
  } commit_t;

  commit_t exp_q[$];
  commit_t mon_exp;
  commit_t mon_got;
  int      n_pass  = 0;
  int      n_total = 0;

  always #5 clk = ~clk;

  cf_commit_queue #(.DEPTH(8), .DEPTH_BITS(3), .ROB_IDX_W(4)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_is_jr(alloc_is_jr), .alloc_rob_idx(alloc_rob_idx),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .res_valid(res_valid), .res_tag(res_tag), .res_taken(res_taken), .res_target(res_target),
    .rob_head_valid(rob_head_valid), .rob_head_idx(rob_head_idx), .flush(flush),
    .valid_branch(valid_branch), .branch_outcome(branch_outcome),
    .valid_jump_reg(valid_jump_reg), .jump_target(jump_target),
    .count(count), .err_sticky(err_sticky)
  );

  // every observed commit pulse is matched in order against the scoreboard
  always @(negedge clk) begin
    if (valid_branch || valid_jump_reg) begin
      n_total++;
      mon_got = valid_jump_reg ? {1'b1, jump_target} : {1'b0, 31'd0, branch_outcome};
      if (exp_q.size() == 0) begin
        $display("FAIL commit_order: unexpected pulse br=%0b jr=%0b got=%h expected none",
                 valid_branch, valid_jump_reg, mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if ((valid_branch && valid_jump_reg) || mon_got !== mon_exp)
          $display("FAIL commit_order: got jr=%0b val=%h expected jr=%0b val=%h",
                   mon_got.is_jr, mon_got.val, mon_exp.is_jr, mon_exp.val);
        else n_pass++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; alloc_valid = 1'b0; alloc_is_jr = 1'b0; alloc_rob_idx = '0;
    res_valid = 1'b0; res_tag = '0; res_taken = 1'b0; res_target = '0;
    rob_head_valid = 1'b0; rob_head_idx = '0; flush = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    n_total++; if (count !== 4'd0) $display("FAIL reset_count: got %0d expected 0", count); else n_pass++;
    n_total++; if (alloc_ready !== 1'b1) $display("FAIL reset_ready: got %0b expected 1", alloc_ready); else n_pass++;
    n_total++; if ({valid_branch, valid_jump_reg} !== 2'b00) $display("FAIL reset_pulses: got %b expected 00", {valid_branch, valid_jump_reg}); else n_pass++;
    n_total++; if (err_sticky !== 1'b0) $display("FAIL reset_err: got %0b expected 0", err_sticky); else n_pass++;
    n_total++; if (alloc_tag !== 3'd0) $display("FAIL reset_tag: got %0d expected 0", alloc_tag); else n_pass++;
    n_total++; if (jump_target !== 32'd0) $display("FAIL reset_target: got %h expected 0", jump_target); else n_pass++;
  endtask

  task automatic test_branch();
    alloc_valid = 1'b1; alloc_is_jr = 1'b0; alloc_rob_idx = 4'd3;
    n_total++; if (alloc_tag !== 3'd0) $display("FAIL br_tag: got %0d expected 0", alloc_tag); else n_pass++;
    step();
    alloc_valid = 1'b0;
    res_valid = 1'b1; res_tag = 3'd0; res_taken = 1'b1;
    n_total++; if (count !== 4'd1) $display("FAIL br_count1: got %0d expected 1", count); else n_pass++;
    step();
    res_valid = 1'b0;
    rob_head_valid = 1'b1; rob_head_idx = 4'd3;
    exp_q.push_back({1'b0, 32'd1});
    n_total++; if (valid_branch !== 1'b0) $display("FAIL br_early: got %0b expected 0", valid_branch); else n_pass++;
    step();
    rob_head_valid = 1'b0;
    n_total++; if ({valid_branch, branch_outcome} !== 2'b11) $display("FAIL br_pulse: got %b expected 11", {valid_branch, branch_outcome}); else n_pass++;
    n_total++; if (count !== 4'd0) $display("FAIL br_count0: got %0d expected 0", count); else n_pass++;
    step();
    n_total++; if (valid_branch !== 1'b0) $display("FAIL br_one_cycle: got %0b expected 0", valid_branch); else n_pass++;
  endtask

  task automatic test_jr_order();
    do_reset();
    alloc_valid = 1'b1; alloc_is_jr = 1'b1; alloc_rob_idx = 4'd5;
    n_total++; if (alloc_tag !== 3'd0) $display("FAIL jr_tag0: got %0d expected 0", alloc_tag); else n_pass++;
    step();
    alloc_is_jr = 1'b0; alloc_rob_idx = 4'd6;
    n_total++; if (alloc_tag !== 3'd1) $display("FAIL jr_tag1: got %0d expected 1", alloc_tag); else n_pass++;
    step();
    alloc_valid = 1'b0;
    res_valid = 1'b1; res_tag = 3'd1; res_taken = 1'b0;
    rob_head_valid = 1'b1; rob_head_idx = 4'd5;
    step();
    res_tag = 3'd0; res_taken = 1'b1; res_target = 32'h0040_0100;
    step();
    res_valid = 1'b0;
    n_total++; if ({valid_branch, valid_jump_reg} !== 2'b00) $display("FAIL jr_no_bypass: got %b expected 00", {valid_branch, valid_jump_reg}); else n_pass++;
    n_total++; if (count !== 4'd2) $display("FAIL jr_count2: got %0d expected 2", count); else n_pass++;
    exp_q.push_back({1'b1, 32'h0040_0100});
    step();
    n_total++; if ({valid_jump_reg, valid_branch} !== 2'b10) $display("FAIL jr_pulse: got %b expected 10", {valid_jump_reg, valid_branch}); else n_pass++;
    n_total++; if (jump_target !== 32'h0040_0100) $display("FAIL jr_target: got %h expected 00400100", jump_target); else n_pass++;
    rob_head_idx = 4'd6;
    exp_q.push_back({1'b0, 32'd0});
    step();
    rob_head_valid = 1'b0;
    n_total++; if ({valid_branch, branch_outcome, valid_jump_reg} !== 3'b100) $display("FAIL jr_then_br: got %b expected 100", {valid_branch, branch_outcome, valid_jump_reg}); else n_pass++;
    step();
    n_total++; if (count !== 4'd0) $display("FAIL jr_count0: got %0d expected 0", count); else n_pass++;
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 5; i++) begin
      alloc_valid = 1'b1; alloc_is_jr = 1'b0; alloc_rob_idx = 4'(i);
      step();
    end
    alloc_valid = 1'b0;
    res_valid = 1'b1; res_tag = 3'd2; res_taken = 1'b1;
    step();
    res_tag = 3'd7;
    step();
    res_valid = 1'b0;
    n_total++; if (err_sticky !== 1'b1) $display("FAIL rst_mid_err_set: got %0b expected 1", err_sticky); else n_pass++;
    n_total++; if (count !== 4'd5) $display("FAIL rst_mid_count5: got %0d expected 5", count); else n_pass++;
    rob_head_valid = 1'b1; rob_head_idx = 4'd0;
    rst = 1'b1;
    step();
    n_total++; if ({valid_branch, valid_jump_reg, branch_outcome} !== 3'b000) $display("FAIL rst_mid_pulse: got %b expected 000", {valid_branch, valid_jump_reg, branch_outcome}); else n_pass++;
    n_total++; if (jump_target !== 32'd0) $display("FAIL rst_mid_target: got %h expected 0", jump_target); else n_pass++;
    n_total++; if (count !== 4'd0) $display("FAIL rst_mid_count: got %0d expected 0", count); else n_pass++;
    n_total++; if (err_sticky !== 1'b0) $display("FAIL rst_mid_err: got %0b expected 0", err_sticky); else n_pass++;
    rst = 1'b0;
    step();
    rob_head_valid = 1'b0;
    n_total++; if ({valid_branch, count} !== 5'd0) $display("FAIL rst_mid_after: got br=%0b count=%0d expected 0/0", valid_branch, count); else n_pass++;
  endtask

  task automatic test_fill_wrap();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      alloc_valid = 1'b1; alloc_is_jr = 1'b0; alloc_rob_idx = 4'(i);
      n_total++; if (alloc_tag !== 3'(i)) $display("FAIL fill_tag: got %0d expected %0d", alloc_tag, i); else n_pass++;
      step();
    end
    alloc_rob_idx = 4'd8;
    n_total++; if ({alloc_ready, count} !== {1'b0, 4'd8}) $display("FAIL fill_full: got ready=%0b count=%0d expected 0/8", alloc_ready, count); else n_pass++;
    n_total++; if (err_sticky !== 1'b0) $display("FAIL fill_err_pre: got %0b expected 0", err_sticky); else n_pass++;
    step();
    alloc_valid = 1'b0;
    n_total++; if ({err_sticky, count} !== {1'b1, 4'd8}) $display("FAIL fill_overflow: got err=%0b count=%0d expected 1/8", err_sticky, count); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      res_valid = 1'b1; res_tag = 3'(i); res_taken = i[0];
      step();
    end
    res_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rob_head_valid = 1'b1; rob_head_idx = 4'(i);
      exp_q.push_back({1'b0, 31'd0, i[0]});
      step();
    end
    rob_head_valid = 1'b0;
    n_total++; if (count !== 4'd5) $display("FAIL wrap_count5: got %0d expected 5", count); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1; alloc_rob_idx = 4'(8 + i);
      n_total++; if (alloc_tag !== 3'(i)) $display("FAIL wrap_tag: got %0d expected %0d", alloc_tag, i); else n_pass++;
      step();
    end
    alloc_valid = 1'b0;
    n_total++; if ({alloc_ready, count} !== {1'b0, 4'd8}) $display("FAIL wrap_full: got ready=%0b count=%0d expected 0/8", alloc_ready, count); else n_pass++;
    for (int r = 3; r < 11; r++) begin
      res_valid = 1'b1; res_tag = 3'(r % 8); res_taken = r[0];
      step();
    end
    res_valid = 1'b0;
    for (int r = 3; r < 11; r++) begin
      rob_head_valid = 1'b1; rob_head_idx = 4'(r);
      exp_q.push_back({1'b0, 31'd0, r[0]});
      step();
    end
    rob_head_valid = 1'b0;
    step();
    n_total++; if ({count, alloc_tag} !== {4'd0, 3'd3}) $display("FAIL wrap_drain: got count=%0d tag=%0d expected 0/3", count, alloc_tag); else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1'b1; alloc_is_jr = 1'b0; alloc_rob_idx = 4'(i);
      step();
    end
    alloc_valid = 1'b0;
    res_valid = 1'b1; res_tag = 3'd0; res_taken = 1'b1;
    step();
    res_valid = 1'b0;
    flush = 1'b1;
    alloc_valid = 1'b1; alloc_rob_idx = 4'd12;
    rob_head_valid = 1'b1; rob_head_idx = 4'd0;
    step();
    flush = 1'b0; alloc_valid = 1'b0; rob_head_valid = 1'b0;
    n_total++; if (count !== 4'd0) $display("FAIL flush_count: got %0d expected 0", count); else n_pass++;
    n_total++; if ({alloc_ready, alloc_tag} !== {1'b1, 3'd4}) $display("FAIL flush_wrptr: got ready=%0b tag=%0d expected 1/4", alloc_ready, alloc_tag); else n_pass++;
    n_total++; if (err_sticky !== 1'b0) $display("FAIL flush_err: got %0b expected 0", err_sticky); else n_pass++;
    step();
    n_total++; if (valid_branch !== 1'b0) $display("FAIL flush_no_pulse: got %0b expected 0", valid_branch); else n_pass++;
    res_valid = 1'b1; res_tag = 3'd1; res_taken = 1'b0;
    step();
    res_valid = 1'b0;
    n_total++; if (err_sticky !== 1'b1) $display("FAIL flush_invalidated: got %0b expected 1", err_sticky); else n_pass++;
    alloc_valid = 1'b1; alloc_rob_idx = 4'd9;
    step();
    alloc_valid = 1'b0;
    res_valid = 1'b1; res_tag = 3'd4; res_taken = 1'b0;
    step();
    res_valid = 1'b0;
    rob_head_valid = 1'b1; rob_head_idx = 4'd9;
    exp_q.push_back({1'b0, 32'd0});
    step();
    rob_head_valid = 1'b0;
    n_total++; if ({valid_branch, count} !== {1'b1, 4'd0}) $display("FAIL flush_recover: got br=%0b count=%0d expected 1/0", valid_branch, count); else n_pass++;
    step();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_branch();
    test_jr_order();
    test_rst_mid();
    test_fill_wrap();
    test_flush();
    step();
    n_total++; if (exp_q.size() != 0) $display("FAIL missing_commits: got %0d pending expected 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
